// File: rtl/render_sequencer_if.sv
// Handshake bundle between the composer/renderers and the per-scanline render sequencer.
// The sequencer connects through the slave modport; the composer side drives through master.
interface render_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             line_render_start;
  logic [8:0]       line_idx;
  logic             layer0_enabled;
  logic             layer1_enabled;
  logic             sprites_enabled;
  logic             layer0_done;
  logic             layer1_done;
  logic             sprite_done;
  logic             stats_clear;
  logic             layer0_start;
  logic             layer1_start;
  logic             sprite_start;
  logic             render_abort;
  logic [8:0]       render_line_idx;
  logic             render_bank;
  logic             display_bank;
  logic             busy;
  logic             line_done;
  logic [CNT_W-1:0] overrun_count;
  logic [CNT_W-1:0] timeout_count;

  modport master (
    output line_render_start, line_idx, layer0_enabled, layer1_enabled, sprites_enabled,
           layer0_done, layer1_done, sprite_done, stats_clear,
    input  layer0_start, layer1_start, sprite_start, render_abort, render_line_idx,
           render_bank, display_bank, busy, line_done, overrun_count, timeout_count
  );

  modport slave (
    input  line_render_start, line_idx, layer0_enabled, layer1_enabled, sprites_enabled,
           layer0_done, layer1_done, sprite_done, stats_clear,
    output layer0_start, layer1_start, sprite_start, render_abort, render_line_idx,
           render_bank, display_bank, busy, line_done, overrun_count, timeout_count
  );
endinterface

// File: rtl/render_sequencer.sv
// Runs layer 0, layer 1 and sprite renderers one at a time per scanline, owns the
// ping-pong bank, per-stage watchdog and overrun/timeout statistics.
module render_sequencer #(
  parameter int TIMEOUT_CYCLES = 800,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  render_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, L0, L1, SPR} state_t;

  // Watchdog counts completed cycles in the stage; expiry is detected on the
  // stage's (TIMEOUT_CYCLES-1)th cycle so the next start lands at T+TIMEOUT_CYCLES.
  localparam int               WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // IDLE doubles as "before L0", so the same walk yields the first stage of a line.
  function automatic state_t next_stage(state_t s, logic [2:0] m);
    state_t r;
    r = IDLE;
    case (s)
      IDLE:    r = m[0] ? L0 : (m[1] ? L1 : (m[2] ? SPR : IDLE));
      L0:      r = m[1] ? L1 : (m[2] ? SPR : IDLE);
      L1:      r = m[2] ? SPR : IDLE;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  state_t           state_q;
  logic [2:0]       mask_q;
  logic [WD_W-1:0]  wdog_q;
  logic             l0_start_q, l1_start_q, spr_start_q;
  logic             abort_q, line_done_q, busy_q;
  logic [8:0]       line_idx_q;
  logic             render_bank_q, display_bank_q;
  logic [CNT_W-1:0] ovr_cnt_q, to_cnt_q;

  logic [2:0] en_new;
  state_t     first_stage, adv_stage, tgt;
  logic       stage_done, wd_exp, advance, completes, overrun, timeout, entering;

  always_comb begin
    en_new      = {bus.sprites_enabled, bus.layer1_enabled, bus.layer0_enabled};
    first_stage = next_stage(IDLE, en_new);
    adv_stage   = next_stage(state_q, mask_q);
    stage_done  = 1'b0;
    case (state_q)
      L0:      stage_done = bus.layer0_done;
      L1:      stage_done = bus.layer1_done;
      SPR:     stage_done = bus.sprite_done;
      default: stage_done = 1'b0;
    endcase
    wd_exp    = (state_q != IDLE) && (wdog_q == WD_LAST);
    advance   = stage_done || wd_exp;
    // A start racing the final done finishes the old line cleanly instead of aborting it.
    completes = stage_done && (adv_stage == IDLE);
    overrun   = bus.line_render_start && (state_q != IDLE) && !completes;
    timeout   = !bus.line_render_start && wd_exp && !stage_done;
    entering  = bus.line_render_start || advance;
    tgt       = bus.line_render_start ? first_stage : (advance ? adv_stage : state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      wdog_q         <= '0;
      l0_start_q     <= 1'b0;
      l1_start_q     <= 1'b0;
      spr_start_q    <= 1'b0;
      abort_q        <= 1'b0;
      line_done_q    <= 1'b0;
      busy_q         <= 1'b0;
      line_idx_q     <= '0;
      render_bank_q  <= 1'b0;
      display_bank_q <= 1'b1;
      ovr_cnt_q      <= '0;
      to_cnt_q       <= '0;
    end else begin
      state_q     <= tgt;
      busy_q      <= (tgt != IDLE);
      l0_start_q  <= entering && (tgt == L0);
      l1_start_q  <= entering && (tgt == L1);
      spr_start_q <= entering && (tgt == SPR);
      abort_q     <= overrun || timeout;
      line_done_q <= (entering && (tgt == IDLE)) || (bus.line_render_start && completes);
      if (entering)              wdog_q <= '0;
      else if (state_q != IDLE)  wdog_q <= wdog_q + 1'b1;
      if (bus.line_render_start) begin
        line_idx_q     <= bus.line_idx;
        mask_q         <= en_new;
        render_bank_q  <= ~render_bank_q;
        display_bank_q <= render_bank_q;
      end
      if (bus.stats_clear) begin
        ovr_cnt_q <= '0;
        to_cnt_q  <= '0;
      end else begin
        if (overrun && ovr_cnt_q != CNT_MAX) ovr_cnt_q <= ovr_cnt_q + 1'b1;
        if (timeout && to_cnt_q  != CNT_MAX) to_cnt_q  <= to_cnt_q + 1'b1;
      end
    end
  end

  assign bus.layer0_start    = l0_start_q;
  assign bus.layer1_start    = l1_start_q;
  assign bus.sprite_start    = spr_start_q;
  assign bus.render_abort    = abort_q;
  assign bus.line_done       = line_done_q;
  assign bus.busy            = busy_q;
  assign bus.render_line_idx = line_idx_q;
  assign bus.render_bank     = render_bank_q;
  assign bus.display_bank    = display_bank_q;
  assign bus.overrun_count   = ovr_cnt_q;
  assign bus.timeout_count   = to_cnt_q;
endmodule

// File: tb/tb_render_sequencer.sv
// Randomized bench for render_sequencer against a line-level reference model.
module tb_render_sequencer;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   exp_ovr = 0;
  int   exp_to = 0;
  logic exp_bank = 1'b0;

  render_sequencer_if #(.CNT_W(8)) bus();
  render_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] starts();
    return {bus.sprite_start, bus.layer1_start, bus.layer0_start};
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic drive_start(input logic [8:0] idx, input logic [2:0] m);
    bus.line_idx          = idx;
    bus.layer0_enabled    = m[0];
    bus.layer1_enabled    = m[1];
    bus.sprites_enabled   = m[2];
    bus.line_render_start = 1'b1;
  endtask

  // Hold every done high until the line finishes; bounded so a stuck DUT still ends.
  task automatic drain();
    bit seen = 0;
    bus.layer0_done = 1'b1; bus.layer1_done = 1'b1; bus.sprite_done = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.line_done === 1'b1) seen = 1;
    end
    bus.layer0_done = 1'b0; bus.layer1_done = 1'b0; bus.sprite_done = 1'b0;
    checks++;
    if (!seen) begin errs++; $display("FAIL drain: line_done never seen within 40 cycles"); end
  endtask

  // One line through the model: enabled stages run in order; delay d means done
  // d cycles after the start pulse, and d >= TO-1 lets the watchdog fire instead.
  task automatic run_line(input logic [8:0] idx, input logic [2:0] m, input int d0, input int d1, input int d2);
    int dl[3];
    logic [2:0] nz;
    dl[0] = d0; dl[1] = d1; dl[2] = d2;
    drive_start(idx, m);
    tick();
    bus.line_render_start = 1'b0;
    nz = 3'($urandom);
    bus.layer0_enabled = nz[0]; bus.layer1_enabled = nz[1]; bus.sprites_enabled = nz[2];
    exp_bank = ~exp_bank;
    checks++;
    if (bus.render_line_idx !== idx || bus.render_bank !== exp_bank || bus.display_bank !== ~exp_bank) begin
      errs++;
      $display("FAIL line_latch: idx=%0d bank=%b disp=%b want idx=%0d bank=%b disp=%b",
               bus.render_line_idx, bus.render_bank, bus.display_bank, idx, exp_bank, ~exp_bank);
    end
    if (m == 3'b000) begin
      checks++;
      if (bus.line_done !== 1'b1 || bus.busy !== 1'b0 || starts() !== 3'b000) begin
        errs++;
        $display("FAIL empty_mask: line_done=%b busy=%b starts=%b want 1 0 000", bus.line_done, bus.busy, starts());
      end
      return;
    end
    for (int s = 0; s < 3; s++) begin
      if (!m[s]) continue;
      checks++;
      if (starts() !== (3'b001 << s) || bus.busy !== 1'b1 || bus.line_done !== 1'b0) begin
        errs++;
        $display("FAIL stage_start: starts=%b busy=%b line_done=%b want starts=%b busy=1 line_done=0",
                 starts(), bus.busy, bus.line_done, 3'b001 << s);
      end
      if (dl[s] <= TO - 2) begin
        repeat (dl[s] - 1) tick();
        nz = 3'($urandom);
        nz[s] = 1'b1;
        bus.layer0_done = nz[0]; bus.layer1_done = nz[1]; bus.sprite_done = nz[2];
        tick();
        bus.layer0_done = 1'b0; bus.layer1_done = 1'b0; bus.sprite_done = 1'b0;
        checks++;
        if (bus.render_abort !== 1'b0) begin
          errs++; $display("FAIL done_no_abort: render_abort=%b want 0", bus.render_abort);
        end
      end else begin
        repeat (TO - 1) tick();
        exp_to = sat(exp_to + 1);
        checks++;
        if (bus.render_abort !== 1'b1 || bus.timeout_count !== 8'(exp_to)) begin
          errs++;
          $display("FAIL watchdog: abort=%b timeout_count=%0d want abort=1 timeout_count=%0d",
                   bus.render_abort, bus.timeout_count, exp_to);
        end
      end
    end
    checks++;
    if (bus.line_done !== 1'b1 || bus.busy !== 1'b0 || starts() !== 3'b000) begin
      errs++;
      $display("FAIL line_end: line_done=%b busy=%b starts=%b want 1 0 000", bus.line_done, bus.busy, starts());
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({starts(), bus.render_abort, bus.line_done, bus.busy, bus.render_line_idx, bus.render_bank,
         bus.display_bank, bus.overrun_count, bus.timeout_count} !== {3'b000, 3'b000, 9'd0, 2'b01, 16'd0}) begin
      errs++;
      $display("FAIL reset_state: starts=%b abort=%b done=%b busy=%b idx=%0d bank=%b disp=%b ovr=%0d to=%0d",
               starts(), bus.render_abort, bus.line_done, bus.busy, bus.render_line_idx,
               bus.render_bank, bus.display_bank, bus.overrun_count, bus.timeout_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_enabled();
    run_line(9'd37, 3'b111, 12, 12, 12);
    run_line(9'd100, 3'b100, 3, 3, 5);
    run_line(9'd101, 3'b000, 1, 1, 1);
    checks++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL empty_busy: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_watchdog();
    run_line(9'd200, 3'b111, 4, 30, 2);
    run_line(9'd201, 3'b001, TO - 2, 1, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_line(9'($urandom), 3'($urandom), $urandom_range(1, 18), $urandom_range(1, 18), $urandom_range(1, 18));
  endtask

  task automatic test_overrun();
    drive_start(9'd5, 3'b111);
    tick();
    bus.line_render_start = 1'b0;
    exp_bank = ~exp_bank;
    repeat (2) tick();
    bus.layer0_done = 1'b1;
    tick();
    bus.layer0_done = 1'b0;
    repeat (2) tick();
    drive_start(9'd6, 3'b111);
    tick();
    bus.line_render_start = 1'b0;
    exp_bank = ~exp_bank;
    exp_ovr = sat(exp_ovr + 1);
    checks++;
    if (bus.render_abort !== 1'b1 || starts() !== 3'b001 || bus.overrun_count !== 8'(exp_ovr) ||
        bus.render_bank !== exp_bank || bus.render_line_idx !== 9'd6) begin
      errs++;
      $display("FAIL overrun_l1: abort=%b starts=%b ovr=%0d bank=%b idx=%0d want 1 001 %0d %b 6",
               bus.render_abort, starts(), bus.overrun_count, bus.render_bank, bus.render_line_idx, exp_ovr, exp_bank);
    end
    // A non-final done racing a start is still an overrun.
    bus.layer0_done = 1'b1;
    drive_start(9'd7, 3'b010);
    tick();
    bus.line_render_start = 1'b0; bus.layer0_done = 1'b0;
    exp_bank = ~exp_bank;
    exp_ovr = sat(exp_ovr + 1);
    checks++;
    if (bus.render_abort !== 1'b1 || starts() !== 3'b010 || bus.overrun_count !== 8'(exp_ovr) || bus.line_done !== 1'b0) begin
      errs++;
      $display("FAIL overrun_nonfinal: abort=%b starts=%b ovr=%0d done=%b want 1 010 %0d 0",
               bus.render_abort, starts(), bus.overrun_count, bus.line_done, exp_ovr);
    end
    drain();
  endtask

  task automatic test_coincident();
    drive_start(9'd8, 3'b001);
    tick();
    bus.line_render_start = 1'b0;
    exp_bank = ~exp_bank;
    repeat (2) tick();
    bus.layer0_done = 1'b1;
    drive_start(9'd9, 3'b100);
    tick();
    bus.line_render_start = 1'b0; bus.layer0_done = 1'b0;
    exp_bank = ~exp_bank;
    checks++;
    if (bus.line_done !== 1'b1 || bus.render_abort !== 1'b0 || starts() !== 3'b100 ||
        bus.overrun_count !== 8'(exp_ovr) || bus.render_line_idx !== 9'd9 || bus.render_bank !== exp_bank) begin
      errs++;
      $display("FAIL coincident_done: done=%b abort=%b starts=%b ovr=%0d idx=%0d bank=%b want 1 0 100 %0d 9 %b",
               bus.line_done, bus.render_abort, starts(), bus.overrun_count, bus.render_line_idx, bus.render_bank,
               exp_ovr, exp_bank);
    end
    drain();
    // Start landing on the watchdog expiry cycle counts only as an overrun.
    drive_start(9'd10, 3'b001);
    tick();
    bus.line_render_start = 1'b0;
    exp_bank = ~exp_bank;
    repeat (TO - 2) tick();
    drive_start(9'd11, 3'b001);
    tick();
    bus.line_render_start = 1'b0;
    exp_bank = ~exp_bank;
    exp_ovr = sat(exp_ovr + 1);
    checks++;
    if (bus.render_abort !== 1'b1 || starts() !== 3'b001 || bus.overrun_count !== 8'(exp_ovr) ||
        bus.timeout_count !== 8'(exp_to)) begin
      errs++;
      $display("FAIL start_at_expiry: abort=%b starts=%b ovr=%0d to=%0d want 1 001 %0d %0d",
               bus.render_abort, starts(), bus.overrun_count, bus.timeout_count, exp_ovr, exp_to);
    end
    drain();
  endtask

  task automatic test_saturation();
    drive_start(9'd20, 3'b111);
    tick();
    exp_bank = ~exp_bank;
    for (int i = 0; i < 260; i++) begin
      tick();
      exp_bank = ~exp_bank;
      exp_ovr = sat(exp_ovr + 1);
    end
    checks++;
    if (bus.overrun_count !== 8'(exp_ovr) || exp_ovr != 255) begin
      errs++; $display("FAIL ovr_saturate: overrun_count=%0d want %0d", bus.overrun_count, exp_ovr);
    end
    bus.stats_clear = 1'b1;
    tick();
    bus.stats_clear = 1'b0;
    exp_bank = ~exp_bank;
    exp_ovr = 0; exp_to = 0;
    checks++;
    if (bus.overrun_count !== 8'd0 || bus.timeout_count !== 8'd0) begin
      errs++; $display("FAIL stats_clear: ovr=%0d to=%0d want 0 0", bus.overrun_count, bus.timeout_count);
    end
    tick();
    bus.line_render_start = 1'b0;
    exp_bank = ~exp_bank;
    exp_ovr = 1;
    checks++;
    if (bus.overrun_count !== 8'd1 || bus.render_bank !== exp_bank) begin
      errs++; $display("FAIL ovr_after_clear: ovr=%0d bank=%b want 1 %b", bus.overrun_count, bus.render_bank, exp_bank);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drive_start(9'd300, 3'b100);
    tick();
    bus.line_render_start = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({starts(), bus.render_abort, bus.line_done, bus.busy, bus.render_line_idx, bus.render_bank,
         bus.display_bank, bus.overrun_count, bus.timeout_count} !== {3'b000, 3'b000, 9'd0, 2'b01, 16'd0}) begin
      errs++;
      $display("FAIL reset_mid_spr: starts=%b abort=%b done=%b busy=%b idx=%0d bank=%b disp=%b ovr=%0d to=%0d",
               starts(), bus.render_abort, bus.line_done, bus.busy, bus.render_line_idx,
               bus.render_bank, bus.display_bank, bus.overrun_count, bus.timeout_count);
    end
    tick();
    rst = 1'b0;
    exp_bank = 1'b0; exp_ovr = 0; exp_to = 0;
    run_line(9'd301, 3'b011, 2, 2, 2);
  endtask

  initial begin
    bus.line_render_start = 1'b0;
    bus.line_idx = '0;
    bus.layer0_enabled = 1'b0; bus.layer1_enabled = 1'b0; bus.sprites_enabled = 1'b0;
    bus.layer0_done = 1'b0; bus.layer1_done = 1'b0; bus.sprite_done = 1'b0;
    bus.stats_clear = 1'b0;
    test_reset();
    test_all_enabled();
    test_watchdog();
    test_random();
    test_overrun();
    test_coincident();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/render_sequencer.md
# render_sequencer

Per-scanline controller that sequences the layer 0, layer 1 and sprite line renderers. It sits between the composer's line-start output and the three renderers, which share a single VRAM fetch port and so must run one at a time. It owns the ping-pong line-buffer bank selection, aborts unfinished lines on overrun, enforces a per-stage watchdog, and keeps overrun/timeout statistics for the register interface.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 800: maximum clk cycles one stage may stay active before it is forced to finish; must be ≥ 2.
- `CNT_W`, default 8: width of the saturating statistics counters.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `line_render_start`  in  1  one-cycle pulse from the composer: render the next line
- `line_idx`  in  9  line number to render; sampled with `line_render_start`
- `layer0_enabled`, `layer1_enabled`, `sprites_enabled`  in  1 each  stage enables; sampled with `line_render_start`
- `layer0_done`, `layer1_done`, `sprite_done`  in  1 each  one-cycle completion pulses from the renderers
- `stats_clear`  in  1  pulse: zero both statistics counters
- `layer0_start`, `layer1_start`, `sprite_start`  out  1 each  one-cycle start pulses to the renderers
- `render_abort`  out  1  one-cycle pulse: the active renderer must stop immediately
- `render_line_idx`  out  9  latched line number for the renderers
- `render_bank`  out  1  line-buffer bank the renderers write
- `display_bank`  out  1  bank the composer reads; always `~render_bank`
- `busy`  out  1  high while any stage is in progress
- `line_done`  out  1  one-cycle pulse when a line completes, normally or by timeout
- `overrun_count`  out  CNT_W  saturating count of lines aborted by a new start
- `timeout_count`  out  CNT_W  saturating count of stages ended by the watchdog

## Operation
- States: IDLE, L0, L1, SPR.
- Fixed stage order: L0 → L1 → SPR. Disabled stages are skipped.
- Accepted start (`line_render_start` high, in any state):
  - Latch `line_idx` into `render_line_idx`.
  - Latch the enables into a 3-bit mask. Enable changes mid-line have no effect until the next start.
  - Toggle `render_bank`.
  - Enter the first enabled stage, pulse its start, and clear the watchdog.
  - With an empty mask: stay in IDLE and pulse `line_done`.
- In stage X:
  - X's done pulse advances to the next enabled stage, pulsing its start.
  - If X is the last enabled stage, the done pulse returns to IDLE and pulses `line_done`.
  - Done pulses from non-active renderers are ignored.
- Watchdog:
  - Counts cycles spent in the current stage.
  - When the count reaches `TIMEOUT_CYCLES - 1` with no done pulse, pulse `render_abort`, increment `timeout_count`, and advance exactly as if done had arrived.
- Overrun: `line_render_start` while not IDLE.
  - Pulse `render_abort` and increment `overrun_count`.
  - Then handle the start as an accepted start.
  - Exception: if the active stage's done arrives in the same cycle and would have completed the line, this is not an overrun. There is no abort, `line_done` pulses, and the new line starts.
- Start and watchdog expiry in the same cycle: treat as an overrun only. `timeout_count` does not increment.
- Counters saturate at all-ones. `stats_clear` zeroes both; an increment in the same cycle is lost.

## Timing
- All outputs are registered.
- Reset values: starts 0, `render_abort` 0, `line_done` 0, `busy` 0, `render_line_idx` 0, `render_bank` 0, `display_bank` 1, both counters 0, state IDLE.
- Start sampled at edge T:
  - First stage start pulse, `busy`=1, new `render_line_idx`, and toggled bank are all visible from T+1.
  - Empty mask: `line_done` high at T+1 and `busy` stays 0.
- Done sampled at edge D:
  - Next start pulse is high at D+1.
  - If it was the last stage: `line_done` high and `busy` low at D+1.
- Watchdog: with no done, a stage started at T+1 produces `render_abort` and the next start pulse at T+`TIMEOUT_CYCLES`.
- Overrun: `render_abort` and the new first-stage start are high in the same cycle. The renderers must give abort priority, then start.
- `rst` mid-line: immediate return to reset values, with no abort or done pulses.

## Test plan
- All enabled, `line_idx`=37, each done 50 cycles after its start → starts in order L0, L1, SPR; `render_line_idx`=37; `line_done` one cycle after `sprite_done`; `render_bank` 0→1.
- Only `sprites_enabled` → `sprite_start` at T+1 and no layer starts. All disabled → `line_done` at T+1 and `busy` never high.
- `TIMEOUT_CYCLES`=16, `layer1_done` withheld → abort and `sprite_start` 15 cycles after `layer1_start`; `timeout_count`=1.
- New start during L1 → `render_abort` and `layer0_start` in the same cycle; `overrun_count`=1; bank toggles twice over the two lines.
- Final done coincident with a new start → `line_done`=1, no abort, `overrun_count` unchanged.
- 260 forced overruns with `CNT_W`=8 → count holds at 255; `stats_clear` → 0. Assert `rst` mid-SPR → all outputs return to reset values.
